pipe_rr_arbiter: RTL and testbench

- Merges N independent 128-bit method-to-pipe output streams onto the single top-level indication pipe (enq ENA/RDY interface).
- Each source gets a one-entry holding register. A round-robin scheduler drains the full holding registers into the shared pipe, one message per cycle.
- A configuration method sets a grant-enable mask so software or a test harness can pause individual sources.
- Sits in the top-level wrapper, between the M2P serializers and the external indication pipe.

---
 rtl/pipe_rr_arbiter_pkg.sv | 13 +
 rtl/pipe_rr_arbiter_rr_pick.sv | 32 +++
 rtl/pipe_rr_arbiter.sv | 88 ++++++++
 tb/tb_pipe_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_rr_arbiter_pkg.sv
// Shared defaults for the indication-side pipe blocks (arbiter, M2P/P2M serializers).
// Width of one enq message and default source count, plus a pointer-width helper.
package pipe_rr_arbiter_pkg;

    localparam int PIPE_WIDTH = 128;
    localparam int PIPE_N     = 2;

    // Pointer width for an N-way scheduler; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first eligible index at or after ptr_i, wrapping modulo N.
// Purely combinational so it can also drive a request-side demux scheduler.
module pipe_rr_arbiter_rr_pick #(
    parameter int N    = 2,
    parameter int LOGN = 1
) (
    input  logic [N-1:0]    eligible_i,
    input  logic [LOGN-1:0] ptr_i,
    output logic [LOGN-1:0] sel_o,
    output logic            any_o
);

    int              idx;
    logic [LOGN-1:0] idx_w;

    // Scan from the far end back towards ptr_i so the nearest eligible index wins.
    always_comb begin
        sel_o = '0;
        any_o = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx   = (int'(ptr_i) + k) % N;
            idx_w = LOGN'(idx);
            if (eligible_i[idx_w]) begin
                sel_o = idx_w;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Merges N enq streams onto the single indication pipe through one-entry holding slots
// drained round-robin, with a software grant mask to pause individual sources.
module pipe_rr_arbiter
    import pipe_rr_arbiter_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int WIDTH = PIPE_WIDTH,
    parameter int LOGN  = ptr_width(N)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [N-1:0]       src_enq__ENA,
    input  logic [N*WIDTH-1:0] src_enq_v,
    output logic [N-1:0]       src_enq__RDY,
    output logic               indication_enq__ENA,
    output logic [WIDTH-1:0]   indication_enq_v,
    input  logic               indication_enq__RDY,
    input  logic               cfg_setMask__ENA,
    input  logic [N-1:0]       cfg_setMask_mask,
    output logic               cfg_setMask__RDY,
    output logic               busy
);

    logic [N-1:0]     hold_full_q, hold_full_d;
    logic [N-1:0]     mask_q;
    logic [N-1:0]     eligible;
    logic [N-1:0]     accept;
    logic [WIDTH-1:0] hold_data_q [N];
    logic [LOGN-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LOGN-1:0]  sel;
    logic             any;
    logic             drain;

    assign eligible = hold_full_q & mask_q;

    pipe_rr_arbiter_rr_pick #(
        .N    (N),
        .LOGN (LOGN)
    ) u_rr_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .sel_o      (sel),
        .any_o      (any)
    );

    // Strobes into an already-full slot are protocol violations and are dropped.
    assign accept = src_enq__ENA & ~hold_full_q & {N{nRST}};
    assign drain  = nRST & any & indication_enq__RDY;

    assign indication_enq__ENA = drain;
    assign indication_enq_v    = hold_data_q[sel];
    assign src_enq__RDY        = nRST ? ~hold_full_q : '0;
    assign cfg_setMask__RDY    = nRST;
    assign busy                = |hold_full_q;

    always_comb begin
        hold_full_d = hold_full_q | accept;
        rr_ptr_d    = rr_ptr_q;
        if (drain) begin
            hold_full_d[sel] = 1'b0;
            rr_ptr_d         = (sel == LOGN'(N - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold_full_q <= '0;
            rr_ptr_q    <= '0;
            mask_q      <= '1;
        end else begin
            hold_full_q <= hold_full_d;
            rr_ptr_q    <= rr_ptr_d;
            if (cfg_setMask__ENA) begin
                mask_q <= cfg_setMask_mask;
            end
        end
    end

    // Payload storage carries no reset; validity lives entirely in hold_full_q.
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        always_ff @(posedge CLK) begin
            if (accept[gi]) begin
                hold_data_q[gi] <= src_enq_v[gi*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Scoreboard bench for pipe_rr_arbiter (N=2): expected payloads are queued when
// sources are driven and popped by a monitor whenever the indication pipe fires.
module tb_pipe_rr_arbiter;

    localparam int N = 2;
    localparam int W = 128;

    logic           clk;
    logic           nrst;
    logic [N-1:0]   src_ena;
    logic [N*W-1:0] src_v;
    logic [N-1:0]   src_rdy;
    logic           ind_ena;
    logic [W-1:0]   ind_v;
    logic           ind_rdy;
    logic           cfg_ena;
    logic [N-1:0]   cfg_mask;
    logic           cfg_rdy;
    logic           busy;

    int             tests_run;
    int             tests_failed;
    logic [W-1:0]   exp_q [$];

    pipe_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .CLK                 (clk),
        .nRST                (nrst),
        .src_enq__ENA        (src_ena),
        .src_enq_v           (src_v),
        .src_enq__RDY        (src_rdy),
        .indication_enq__ENA (ind_ena),
        .indication_enq_v    (ind_v),
        .indication_enq__RDY (ind_rdy),
        .cfg_setMask__ENA    (cfg_ena),
        .cfg_setMask_mask    (cfg_mask),
        .cfg_setMask__RDY    (cfg_rdy),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src(input logic [N-1:0] en, input logic [W-1:0] d0, input logic [W-1:0] d1);
        src_ena = en;
        src_v   = {d1, d0};
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check_val(tag, W'(exp_q.size()), '0);
    endtask

    // Monitor: every indication enq must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nrst && (src_ena != '0)) begin
            check_val("src_protocol", W'(src_ena & ~src_rdy), '0);
        end
        if (ind_ena) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_enq", ind_v, '0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                $display("[TB] indication enq v=%h expected %h", ind_v, e);
                check_val("enq_payload", ind_v, e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        nrst     = 1'b0;
        src_ena  = '0;
        src_v    = '0;
        ind_rdy  = 1'b1;
        cfg_ena  = 1'b0;
        cfg_mask = '0;

        // Reset: everything forced low, then idle/ready on release.
        repeat (3) cyc();
        @(negedge clk);
        check_val("rst_src_rdy", W'(src_rdy), '0);
        check_val("rst_ind_ena", W'(ind_ena), '0);
        check_val("rst_cfg_rdy", W'(cfg_rdy), '0);
        cyc();
        nrst = 1'b1;
        @(negedge clk);
        check_val("post_rst_src_rdy", W'(src_rdy), W'(2'b11));
        check_val("post_rst_ind_ena", W'(ind_ena), '0);
        check_val("post_rst_busy", W'(busy), '0);
        check_val("post_rst_cfg_rdy", W'(cfg_rdy), W'(1'b1));

        // Single source 0, one-cycle latency, slot frees the cycle after drain.
        cyc();
        drive_src(2'b01, W'(128'hA5), '0);
        exp_q.push_back(W'(128'hA5));
        @(negedge clk);
        check_val("single_latency", W'(ind_ena), '0);
        cyc();
        drive_src(2'b00, '0, '0);
        @(negedge clk);
        check_val("single_ena", W'(ind_ena), W'(1'b1));
        check_val("single_src_rdy", W'(src_rdy), W'(2'b10));
        cyc();
        @(negedge clk);
        check_val("single_refree", W'(src_rdy), W'(2'b11));
        check_val("single_busy", W'(busy), '0);

        // Single source 1: pointer goes from 1 back to 0.
        cyc();
        drive_src(2'b10, '0, W'(128'h5A));
        exp_q.push_back(W'(128'h5A));
        cyc();
        drive_src(2'b00, '0, '0);
        @(negedge clk);
        check_val("single1_ena", W'(ind_ena), W'(1'b1));
        cyc();

        // Contention with pointer at 0: strict alternation 0x11, 0x22, twice.
        for (int rep = 0; rep < 2; rep++) begin
            drive_src(2'b11, W'(128'h11), W'(128'h22));
            exp_q.push_back(W'(128'h11));
            exp_q.push_back(W'(128'h22));
            cyc();
            drive_src(2'b00, '0, '0);
            @(negedge clk);
            check_val("cont_both_full", W'(src_rdy), '0);
            cyc();
            @(negedge clk);
            check_val("cont_slot0_free", W'(src_rdy), W'(2'b01));
            cyc();
        end

        // Backpressure: nothing moves, payload stable on v, then drain in order.
        ind_rdy = 1'b0;
        drive_src(2'b11, W'(128'h33), W'(128'h44));
        cyc();
        drive_src(2'b00, '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_ind_ena", W'(ind_ena), '0);
            check_val("bp_src_rdy", W'(src_rdy), '0);
            check_val("bp_v_stable", ind_v, W'(128'h33));
            cyc();
        end
        ind_rdy = 1'b1;
        exp_q.push_back(W'(128'h33));
        exp_q.push_back(W'(128'h44));
        wait_empty("bp_drain", 10);

        // Mask 2'b10: only source 1 is granted; source 0 parks until re-enabled.
        ind_rdy = 1'b0;
        drive_src(2'b11, W'(128'h55), W'(128'h66));
        cyc();
        drive_src(2'b00, '0, '0);
        cfg_ena  = 1'b1;
        cfg_mask = 2'b10;
        cyc();
        cfg_ena = 1'b0;
        ind_rdy = 1'b1;
        exp_q.push_back(W'(128'h66));
        @(negedge clk);
        check_val("mask_src1_ena", W'(ind_ena), W'(1'b1));
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("mask_stall_ena", W'(ind_ena), '0);
            check_val("mask_stall_busy", W'(busy), W'(1'b1));
            check_val("mask_stall_rdy", W'(src_rdy), W'(2'b10));
            cyc();
        end
        cfg_ena  = 1'b1;
        cfg_mask = 2'b11;
        @(negedge clk);
        check_val("mask_load_cycle", W'(ind_ena), '0);
        cyc();
        cfg_ena = 1'b0;
        exp_q.push_back(W'(128'h55));
        @(negedge clk);
        check_val("unmask_ena", W'(ind_ena), W'(1'b1));
        cyc();
        @(negedge clk);
        check_val("unmask_busy", W'(busy), '0);

        // Reset mid-flight with a narrowed mask: slots and mask both restored.
        cyc();
        cfg_ena  = 1'b1;
        cfg_mask = 2'b01;
        ind_rdy  = 1'b0;
        drive_src(2'b11, W'(128'h77), W'(128'h88));
        cyc();
        cfg_ena = 1'b0;
        drive_src(2'b00, '0, '0);
        nrst = 1'b0;
        @(negedge clk);
        check_val("midrst_src_rdy", W'(src_rdy), '0);
        check_val("midrst_cfg_rdy", W'(cfg_rdy), '0);
        cyc();
        nrst    = 1'b1;
        ind_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("midrst_no_enq", W'(ind_ena), '0);
            check_val("midrst_busy", W'(busy), '0);
            check_val("midrst_rdy", W'(src_rdy), W'(2'b11));
            cyc();
        end
        drive_src(2'b11, W'(128'h99), W'(128'hAA));
        exp_q.push_back(W'(128'h99));
        exp_q.push_back(W'(128'hAA));
        cyc();
        drive_src(2'b00, '0, '0);
        wait_empty("midrst_drain", 10);

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
